// File: rtl/xt_hb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xt_hb_arbiter_pkg
// Shared types and encodings for the XT_HB multi-master arbiter:
//   hb_arb_state_e   - arbiter FSM states (IDLE, GRANT, ABORT)
//   HB_WIDTH_*       - XT_HB write-width encodings (byte / half / word)
//   hb_idx_width()   - width of a master index (never below 1 bit)
// ---------------------------------------------------------------------------
package xt_hb_arbiter_pkg;

    typedef enum logic [1:0] {
        HB_ARB_IDLE  = 2'd0,
        HB_ARB_GRANT = 2'd1,
        HB_ARB_ABORT = 2'd2
    } hb_arb_state_e;

    localparam logic [1:0] HB_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] HB_WIDTH_HALF = 2'd1;
    localparam logic [1:0] HB_WIDTH_WORD = 2'd2;

    // A single master still needs a 1-bit index so grant_id is never zero-width.
    function automatic int hb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xt_hb_arbiter_rr_priority_picker.sv
// ---------------------------------------------------------------------------
// xt_hb_arbiter_rr_priority_picker
// Purely combinational winner selection over a request vector.
//   req        in  N   request vector
//   ptr        in  IW  round-robin start index
//   rr_mode    in  1   1 = scan upward from ptr with wrap, 0 = lowest index wins
//   win_onehot out N   one-hot winner (all zero when nothing requests)
//   win_idx    out IW  binary index of the winner (0 when nothing requests)
// ---------------------------------------------------------------------------
module xt_hb_arbiter_rr_priority_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          rr_mode,
    output logic [N-1:0]  win_onehot,
    output logic [IW-1:0] win_idx
);

    // Scan N candidates starting at the pointer (or 0); the first requester wins.
    always_comb begin
        int   start;
        int   cand;
        logic found;
        logic hit;
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        hit        = 1'b0;
        cand       = 0;
        // An out-of-range pointer (non power-of-two N) falls back to index 0.
        start      = (rr_mode && (int'(ptr) < N)) ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            cand             = (start + k) % N;
            hit              = !found && req[cand];
            win_onehot[cand] = hit;
            win_idx          = hit ? IW'(cand) : win_idx;
            found            = found | hit;
        end
    end

endmodule

// File: rtl/xt_hb_arbiter.sv
// ---------------------------------------------------------------------------
// xt_hb_arbiter
// Multi-master front end for the XT_HB bus: arbitrates MASTER_NUM masters onto
// one master port, holds the grant until the slave signals done, and aborts a
// hung transaction after TIMEOUT_CYCLES granted cycles (0 = no watchdog).
// Ports:
//   clk, rst_sync_n           clock, synchronous active-low reset
//   m_read/m_write            per-master requests (read wins if both)
//   m_raddr/m_waddr/m_wdata/m_write_width  per-master transaction fields
//   m_accept/m_error          one-cycle completion / timeout pulse to owner
//   m_rdata                   read data, valid in the m_accept cycle
//   m_stall                   request & ~accept per master
//   bus_*                     forwarded request of the owner (0 outside GRANT)
//   bus_rdata, bus_done       slave read data and wait_finish
//   grant_id                  index of the current/last owner
// ---------------------------------------------------------------------------
module xt_hb_arbiter
    import xt_hb_arbiter_pkg::*;
#(
    parameter int MASTER_NUM     = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk,
    input  logic                                   rst_sync_n,
    input  logic [MASTER_NUM-1:0]                  m_read,
    input  logic [MASTER_NUM-1:0]                  m_write,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0]  m_raddr,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0]  m_waddr,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0]  m_wdata,
    input  logic [MASTER_NUM-1:0][1:0]             m_write_width,
    output logic [MASTER_NUM-1:0]                  m_accept,
    output logic [MASTER_NUM-1:0]                  m_error,
    output logic [DATA_WIDTH-1:0]                  m_rdata,
    output logic [MASTER_NUM-1:0]                  m_stall,
    output logic                                   bus_read,
    output logic                                   bus_write,
    output logic [ADDR_WIDTH-1:0]                  bus_raddr,
    output logic [ADDR_WIDTH-1:0]                  bus_waddr,
    output logic [DATA_WIDTH-1:0]                  bus_wdata,
    output logic [1:0]                             bus_write_width,
    input  logic [DATA_WIDTH-1:0]                  bus_rdata,
    input  logic                                   bus_done,
    output logic [hb_idx_width(MASTER_NUM)-1:0]    grant_id
);

    localparam int              GW        = hb_idx_width(MASTER_NUM);
    localparam int              WW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              WDOG_EN   = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [WW-1:0]   WDOG_LAST = WW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [GW-1:0]   LAST_IDX  = GW'(MASTER_NUM - 1);
    localparam logic            RR_SEL    = (RR_MODE != 0) ? 1'b1 : 1'b0;

    hb_arb_state_e          state_r, state_s;
    logic [GW-1:0]          grant_r, grant_s;
    logic [GW-1:0]          ptr_r, ptr_s;
    logic [GW-1:0]          ptr_adv_s;
    logic [WW-1:0]          wdog_r, wdog_s;
    logic [MASTER_NUM-1:0]  req_s;
    logic [MASTER_NUM-1:0]  win_onehot_s;
    logic [GW-1:0]          win_idx_s;

    // Per-master request: a read, a write, or (illegally) both.
    always_comb begin
        req_s = m_read | m_write;
    end

    xt_hb_arbiter_rr_priority_picker #(
        .N  (MASTER_NUM),
        .IW (GW)
    ) u_picker (
        .req        (req_s),
        .ptr        (ptr_r),
        .rr_mode    (RR_SEL),
        .win_onehot (win_onehot_s),
        .win_idx    (win_idx_s)
    );

    // Pointer after a completed or aborted grant: the master above the owner.
    always_comb begin
        if (grant_r == LAST_IDX) begin
            ptr_adv_s = '0;
        end else begin
            ptr_adv_s = grant_r + GW'(1'b1);
        end
    end

    // Next-state, watchdog and output decode; outputs are quiet outside GRANT.
    always_comb begin
        state_s         = state_r;
        grant_s         = grant_r;
        ptr_s           = ptr_r;
        wdog_s          = wdog_r;
        m_accept        = '0;
        m_error         = '0;
        m_rdata         = '0;
        bus_read        = 1'b0;
        bus_write       = 1'b0;
        bus_raddr       = '0;
        bus_waddr       = '0;
        bus_wdata       = '0;
        bus_write_width = 2'd0;
        case (state_r)
            HB_ARB_IDLE: begin
                if (|win_onehot_s) begin
                    grant_s = win_idx_s;
                    wdog_s  = '0;
                    state_s = HB_ARB_GRANT;
                end else begin
                    state_s = HB_ARB_IDLE;
                end
            end
            HB_ARB_GRANT: begin
                // Read wins over a simultaneous write from the same master.
                bus_read        = m_read[grant_r];
                bus_write       = m_write[grant_r] & ~m_read[grant_r];
                bus_raddr       = m_raddr[grant_r];
                bus_waddr       = m_waddr[grant_r];
                bus_wdata       = m_wdata[grant_r];
                bus_write_width = m_write_width[grant_r];
                if (wdog_r != '1) begin
                    wdog_s = wdog_r + WW'(1'b1);
                end else begin
                    wdog_s = wdog_r;
                end
                // Done has priority over a coincident timeout.
                if (bus_done) begin
                    m_accept[grant_r] = 1'b1;
                    m_rdata           = bus_rdata;
                    ptr_s             = ptr_adv_s;
                    state_s           = HB_ARB_IDLE;
                end else if (WDOG_EN && (wdog_r == WDOG_LAST)) begin
                    m_error[grant_r]  = 1'b1;
                    ptr_s             = ptr_adv_s;
                    state_s           = HB_ARB_ABORT;
                end else begin
                    state_s           = HB_ARB_GRANT;
                end
            end
            HB_ARB_ABORT: begin
                state_s = HB_ARB_IDLE;
            end
            default: begin
                state_s = HB_ARB_IDLE;
            end
        endcase
    end

    // A master stalls while it requests and is not being accepted this cycle.
    always_comb begin
        m_stall = req_s & ~m_accept;
    end

    assign grant_id = grant_r;

    // State, owner, round-robin pointer and watchdog registers.
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            state_r <= HB_ARB_IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
            wdog_r  <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
            wdog_r  <= wdog_s;
        end
    end

endmodule

// File: tb/tb_xt_hb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xt_hb_arbiter
// Bench for xt_hb_arbiter: a round-robin and a fixed-priority instance
// (3 masters, 8-cycle watchdog) share one set of master/slave inputs.
// Directed scenarios plus randomized traffic against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_xt_hb_arbiter;
    import xt_hb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                  clk = 1'b0;
    logic                  rst_sync_n;
    logic [N-1:0]          m_read, m_write;
    logic [N-1:0][AW-1:0]  m_raddr, m_waddr;
    logic [N-1:0][DW-1:0]  m_wdata;
    logic [N-1:0][1:0]     m_write_width;
    logic [DW-1:0]         bus_rdata;
    logic                  bus_done;

    logic [N-1:0]  rr_accept, rr_error, rr_stall;
    logic [DW-1:0] rr_rdata, rr_wdata;
    logic          rr_bread, rr_bwrite;
    logic [AW-1:0] rr_raddr, rr_waddr;
    logic [1:0]    rr_width;
    logic [1:0]    rr_grant;

    logic [N-1:0]  fp_accept, fp_error, fp_stall;
    logic [DW-1:0] fp_rdata, fp_wdata;
    logic          fp_bread, fp_bwrite;
    logic [AW-1:0] fp_raddr, fp_waddr;
    logic [1:0]    fp_width;
    logic [1:0]    fp_grant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xt_hb_arbiter #(.MASTER_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .TIMEOUT_CYCLES(TO)) dut_rr (
        .clk(clk), .rst_sync_n(rst_sync_n), .m_read(m_read), .m_write(m_write),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_write_width(m_write_width),
        .m_accept(rr_accept), .m_error(rr_error), .m_rdata(rr_rdata), .m_stall(rr_stall),
        .bus_read(rr_bread), .bus_write(rr_bwrite), .bus_raddr(rr_raddr), .bus_waddr(rr_waddr),
        .bus_wdata(rr_wdata), .bus_write_width(rr_width), .bus_rdata(bus_rdata),
        .bus_done(bus_done), .grant_id(rr_grant));

    xt_hb_arbiter #(.MASTER_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .TIMEOUT_CYCLES(TO)) dut_fp (
        .clk(clk), .rst_sync_n(rst_sync_n), .m_read(m_read), .m_write(m_write),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_write_width(m_write_width),
        .m_accept(fp_accept), .m_error(fp_error), .m_rdata(fp_rdata), .m_stall(fp_stall),
        .bus_read(fp_bread), .bus_write(fp_bwrite), .bus_raddr(fp_raddr), .bus_waddr(fp_waddr),
        .bus_wdata(fp_wdata), .bus_write_width(fp_width), .bus_rdata(bus_rdata),
        .bus_done(bus_done), .grant_id(fp_grant));

    task automatic idle_inputs();
        m_read = '0; m_write = '0; m_raddr = '0; m_waddr = '0;
        m_wdata = '0; m_write_width = '0; bus_rdata = '0; bus_done = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst_sync_n = 1'b0; idle_inputs();
        @(negedge clk); rst_sync_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst_sync_n = 1'b0; idle_inputs();
        @(negedge clk); #1;
        checks++;
        if ({rr_accept, rr_error, rr_stall, rr_bread, rr_bwrite, rr_grant} !== '0) begin
            errors++; $display("FAIL reset_rr_ctl got=%b want=0", {rr_accept, rr_error, rr_stall, rr_bread, rr_bwrite, rr_grant});
        end
        checks++;
        if ({rr_raddr, rr_waddr, rr_wdata, rr_width, rr_rdata} !== '0) begin
            errors++; $display("FAIL reset_rr_data got=%h want=0", {rr_raddr, rr_waddr, rr_wdata, rr_width, rr_rdata});
        end
        checks++;
        if ({fp_accept, fp_error, fp_stall, fp_bread, fp_bwrite, fp_grant, fp_raddr, fp_waddr, fp_wdata, fp_width, fp_rdata} !== '0) begin
            errors++; $display("FAIL reset_fp got=%h want=0", {fp_accept, fp_error, fp_stall, fp_bread, fp_bwrite, fp_grant, fp_raddr, fp_waddr, fp_wdata, fp_width, fp_rdata});
        end
        @(negedge clk); rst_sync_n = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            m_read[0] = (c < 2); m_raddr[0] = 16'h0804; bus_rdata = 32'hDEADBEEF; bus_done = 1'b1;
            #1;
            if (c == 0) begin
                checks++;
                if (rr_bread !== 1'b0 || rr_accept !== 3'b000 || rr_stall !== 3'b001) begin
                    errors++; $display("FAIL single_arb rd=%b acc=%b stall=%b want 0/000/001", rr_bread, rr_accept, rr_stall);
                end
            end else if (c == 1) begin
                checks++;
                if (rr_bread !== 1'b1 || rr_raddr !== 16'h0804 || rr_accept !== 3'b001 || rr_rdata !== 32'hDEADBEEF || rr_stall !== 3'b000) begin
                    errors++; $display("FAIL single_accept rd=%b addr=%h acc=%b rdata=%h stall=%b want 1/0804/001/deadbeef/000", rr_bread, rr_raddr, rr_accept, rr_rdata, rr_stall);
                end
            end else begin
                checks++;
                if (rr_bread !== 1'b0 || rr_raddr !== 16'h0000 || rr_accept !== 3'b000 || rr_rdata !== 32'h0) begin
                    errors++; $display("FAIL single_after rd=%b addr=%h acc=%b rdata=%h want all 0", rr_bread, rr_raddr, rr_accept, rr_rdata);
                end
            end
        end
    endtask

    task automatic test_rr_fairness();
        logic [2:0] exp_acc;
        apply_reset();
        for (int c = 0; c < 18; c++) begin
            int g;
            @(negedge clk);
            m_read = 3'b111;
            for (int i = 0; i < N; i++) m_raddr[i] = AW'(16'h0100 * (i + 1));
            bus_done = ((c % 3) == 2);
            bus_rdata = 32'hA000_0000 + 32'(c);
            #1;
            g = (c / 3) % 3;                 // expected order 0,1,2,0,1,2
            exp_acc = 3'b000;
            if ((c % 3) == 2) exp_acc[g] = 1'b1;
            checks++;
            if ((c % 3) == 0) begin
                if (rr_bread !== 1'b0 || rr_accept !== 3'b000) begin
                    errors++; $display("FAIL rr_idle c=%0d rd=%b acc=%b want 0/000", c, rr_bread, rr_accept);
                end
            end else begin
                if (rr_bread !== 1'b1 || rr_grant !== 2'(g) || rr_raddr !== AW'(16'h0100 * (g + 1)) || rr_accept !== exp_acc) begin
                    errors++; $display("FAIL rr_grant c=%0d rd=%b gid=%0d addr=%h acc=%b want 1/%0d/%h/%b", c, rr_bread, rr_grant, rr_raddr, rr_accept, g, AW'(16'h0100 * (g + 1)), exp_acc);
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            m_read = 3'b101; bus_done = 1'b1; bus_rdata = 32'(c);
            #1;
            checks++;
            if (fp_stall[2] !== 1'b1 || fp_accept !== ((c % 2) ? 3'b001 : 3'b000) || ((c % 2) == 1 && fp_grant !== 2'd0)) begin
                errors++; $display("FAIL fixed_prio c=%0d stall=%b acc=%b gid=%0d", c, fp_stall, fp_accept, fp_grant);
            end
            // The round-robin instance alternates 0 and 2 on the same traffic.
            checks++;
            if (rr_accept !== ((c % 2) == 0 ? 3'b000 : (((c / 2) % 2) == 0 ? 3'b001 : 3'b100))) begin
                errors++; $display("FAIL rr_alternate c=%0d acc=%b", c, rr_accept);
            end
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m_write[1] = (c < 7); m_waddr[1] = 16'h2468; m_wdata[1] = 32'h12345678;
            m_write_width[1] = HB_WIDTH_HALF; bus_done = (c == 6);
            #1;
            checks++;
            if (c >= 1 && c <= 6) begin
                if (rr_bwrite !== 1'b1 || rr_bread !== 1'b0 || rr_waddr !== 16'h2468 || rr_wdata !== 32'h12345678 ||
                    rr_width !== 2'd1 || rr_grant !== 2'd1 || rr_accept !== ((c == 6) ? 3'b010 : 3'b000)) begin
                    errors++; $display("FAIL wait_grant c=%0d wr=%b addr=%h data=%h w=%0d gid=%0d acc=%b", c, rr_bwrite, rr_waddr, rr_wdata, rr_width, rr_grant, rr_accept);
                end
            end else begin
                if (rr_bwrite !== 1'b0 || rr_accept !== 3'b000 || rr_wdata !== 32'h0) begin
                    errors++; $display("FAIL wait_idle c=%0d wr=%b acc=%b data=%h want 0", c, rr_bwrite, rr_accept, rr_wdata);
                end
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        // Done never comes: error on the 8th GRANT cycle, then one ABORT cycle.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            m_read[2] = (c <= 9); m_raddr[2] = 16'h0F0F; bus_done = (c == 10);
            #1;
            checks++;
            if (c >= 1 && c <= 8) begin
                if (rr_bread !== 1'b1 || rr_accept !== 3'b000 || rr_error !== ((c == 8) ? 3'b100 : 3'b000)) begin
                    errors++; $display("FAIL timeout_grant c=%0d rd=%b acc=%b err=%b", c, rr_bread, rr_accept, rr_error);
                end
            end else begin
                if (rr_bread !== 1'b0 || rr_accept !== 3'b000 || rr_error !== 3'b000) begin
                    errors++; $display("FAIL timeout_quiet c=%0d rd=%b acc=%b err=%b want 0", c, rr_bread, rr_accept, rr_error);
                end
            end
        end
        // Done coincident with the 8th GRANT cycle: accept, no error.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            m_read[2] = (c <= 8); bus_done = (c == 8); bus_rdata = 32'h0BAD_F00D;
            #1;
            if (c == 8) begin
                checks++;
                if (rr_accept !== 3'b100 || rr_error !== 3'b000 || rr_rdata !== 32'h0BAD_F00D) begin
                    errors++; $display("FAIL timeout_done acc=%b err=%b rdata=%h want 100/000/0badf00d", rr_accept, rr_error, rr_rdata);
                end
            end else begin
                checks++;
                if (rr_accept !== 3'b000 || rr_error !== 3'b000) begin
                    errors++; $display("FAIL timeout_done_quiet c=%0d acc=%b err=%b", c, rr_accept, rr_error);
                end
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            m_write[1] = (c < 2); m_waddr[1] = 16'h1111; bus_done = (c == 1) || (c >= 7);
            m_write[2] = (c >= 2 && c < 7); m_waddr[2] = 16'h3000; m_wdata[2] = 32'hCAFEF00D;
            rst_sync_n = !(c == 5 || c == 6);
            m_read = (c >= 7) ? 3'b111 : 3'b000;
            #1;
            if (c == 3 || c == 4) begin
                checks++;
                if (rr_bwrite !== 1'b1 || rr_grant !== 2'd2 || rr_wdata !== 32'hCAFEF00D) begin
                    errors++; $display("FAIL midrst_pre c=%0d wr=%b gid=%0d data=%h", c, rr_bwrite, rr_grant, rr_wdata);
                end
            end else if (c == 6) begin
                checks++;
                if (rr_bwrite !== 1'b0 || rr_accept !== 3'b000 || rr_error !== 3'b000 || rr_grant !== 2'd0 ||
                    rr_waddr !== 16'h0 || rr_wdata !== 32'h0 || rr_rdata !== 32'h0 || rr_stall !== 3'b100) begin
                    errors++; $display("FAIL midrst_reset wr=%b acc=%b err=%b gid=%0d addr=%h stall=%b", rr_bwrite, rr_accept, rr_error, rr_grant, rr_waddr, rr_stall);
                end
            end else if (c == 8) begin
                checks++;
                if (rr_accept !== 3'b001 || rr_grant !== 2'd0) begin
                    errors++; $display("FAIL midrst_first acc=%b gid=%0d want 001/0", rr_accept, rr_grant);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]         pend, is_rd, is_wr;
        logic [N-1:0][AW-1:0] ra, wa;
        logic [N-1:0][DW-1:0] wd;
        logic [N-1:0][1:0]    ww;
        int mode, owner, ptr, gcyc;     // mode: 0 idle, 1 granted, 2 abort
        logic [N-1:0]  e_acc, e_err;
        logic [DW-1:0] e_rdata;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_ra, e_wa;
        logic [DW-1:0] e_wd;
        logic [1:0]    e_ww;
        pend = '0; is_rd = '0; is_wr = '0; ra = '0; wa = '0; wd = '0; ww = '0;
        mode = 0; owner = 0; ptr = 0; gcyc = 0;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    int k;
                    k = $urandom_range(0, 9);
                    pend[i] = 1'b1;
                    is_rd[i] = (k < 5) || (k == 9);
                    is_wr[i] = (k >= 5);
                    ra[i] = AW'($urandom); wa[i] = AW'($urandom); wd[i] = $urandom;
                    ww[i] = 2'($urandom_range(0, 2));
                end
            end
            m_read = pend & is_rd; m_write = pend & is_wr;
            m_raddr = ra; m_waddr = wa; m_wdata = wd; m_write_width = ww;
            bus_done = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
            #1;
            e_acc = '0; e_err = '0; e_rdata = '0; e_rd = 1'b0; e_wr = 1'b0;
            e_ra = '0; e_wa = '0; e_wd = '0; e_ww = 2'd0;
            if (mode == 1) begin
                e_rd = is_rd[owner]; e_wr = is_wr[owner] && !is_rd[owner];
                e_ra = ra[owner]; e_wa = wa[owner]; e_wd = wd[owner]; e_ww = ww[owner];
                if (bus_done) begin
                    e_acc[owner] = 1'b1; e_rdata = bus_rdata;
                end else if (gcyc + 1 == TO) begin
                    e_err[owner] = 1'b1;
                end
            end
            checks++;
            if (rr_accept !== e_acc || rr_error !== e_err || rr_stall !== (pend & ~e_acc) || rr_rdata !== e_rdata) begin
                errors++; $display("FAIL rand_resp cyc=%0d acc=%b/%b err=%b/%b stall=%b/%b rdata=%h/%h", cyc, rr_accept, e_acc, rr_error, e_err, rr_stall, pend & ~e_acc, rr_rdata, e_rdata);
            end
            checks++;
            if ({rr_bread, rr_bwrite, rr_raddr, rr_waddr, rr_wdata, rr_width} !== {e_rd, e_wr, e_ra, e_wa, e_wd, e_ww} ||
                (mode == 1 && rr_grant !== 2'(owner))) begin
                errors++; $display("FAIL rand_bus cyc=%0d got=%h want=%h gid=%0d owner=%0d", cyc, {rr_bread, rr_bwrite, rr_raddr, rr_waddr, rr_wdata, rr_width}, {e_rd, e_wr, e_ra, e_wa, e_wd, e_ww}, rr_grant, owner);
            end
            // Advance the transaction-level model across the coming edge.
            if (mode == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (mode == 0 && pend[(ptr + k) % N]) begin
                        owner = (ptr + k) % N; mode = 1; gcyc = 0;
                    end
                end
            end else if (mode == 1) begin
                gcyc++;
                if (e_acc != '0 || e_err != '0) begin
                    pend[owner] = 1'b0;
                    ptr = (owner + 1) % N;
                    mode = (e_acc != '0) ? 0 : 2;
                end
            end else begin
                mode = 0;
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        rst_sync_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_rr_fairness();
        test_fixed_priority();
        test_wait_states();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/xt_hb_arbiter.md
Name: xt_hb_arbiter

Overview:
- Parametrised multi-master front end for the XT_HB high-speed bus; the first-generation SoC has a single hard-wired master (the core).
- Arbitrates N masters (core plus DMA or debug masters) onto one XT_HB master port, with round-robin or fixed priority.
- Holds each grant across multi-cycle slave transactions that are paced by the slave-side wait_finish.
- Adds a bus-timeout watchdog that aborts hung transactions and reports an error to the requester.

Parameters:
- MASTER_NUM, 2, number of requesting masters; legal range 1..8.
- ADDR_WIDTH, 16, XT_HB byte address width.
- DATA_WIDTH, 32, read/write data width.
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority with master 0 highest.
- TIMEOUT_CYCLES, 255, granted cycles allowed without done before abort; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock; all logic is on the rising edge.
- rst_sync_n  in  1  synchronous active-low reset.
- m_read  in  MASTER_NUM  per-master read request.
- m_write  in  MASTER_NUM  per-master write request.
- m_raddr  in  MASTER_NUM x ADDR_WIDTH  read address per master.
- m_waddr  in  MASTER_NUM x ADDR_WIDTH  write address per master.
- m_wdata  in  MASTER_NUM x DATA_WIDTH  write data per master.
- m_write_width  in  MASTER_NUM x 2  write width per master: 0 byte, 1 half, 2 word.
- m_accept  out  MASTER_NUM  one-cycle completion pulse to the granted master.
- m_error  out  MASTER_NUM  one-cycle timeout pulse to the granted master.
- m_rdata  out  DATA_WIDTH  read data; valid in the m_accept cycle.
- m_stall  out  MASTER_NUM  asserted while a master is requesting and not yet accepted.
- bus_read, bus_write  out  1  forwarded request to the bus.
- bus_raddr, bus_waddr  out  ADDR_WIDTH  forwarded addresses.
- bus_wdata  out  DATA_WIDTH  forwarded write data.
- bus_write_width  out  2  forwarded write width.
- bus_rdata  in  DATA_WIDTH  read data from the decoded slave.
- bus_done  in  1  wait_finish of the decoded slave; 1 = transaction complete this cycle.
- grant_id  out  clog2(MASTER_NUM) or 1  index of the current owner, for debug/observation.

Behaviour:
Reset values:
- All outputs are 0.
- FSM is in IDLE.
- Round-robin pointer is 0, so master 0 wins the first contention.

Request rules:
- A request is (m_read | m_write) for that master.
- Masters hold address, data and width stable until m_accept or m_error.
- Requesting both read and write at once is illegal. If it happens, read wins and write is ignored for that transaction.

FSM:
- IDLE: if any request is present, register the winner in grant_id and go to GRANT. Arbitration costs exactly 1 cycle.
  - RR_MODE=1: the winner is the first requester scanning upward from the pointer, with wrap-around.
  - RR_MODE=0: the winner is the lowest index.
- GRANT: the bus_* outputs mirror the granted master's inputs. All other masters' signals are masked; bus outputs are 0 outside GRANT.
- GRANT with bus_done=1:
  - Pulse m_accept[grant_id].
  - m_rdata = bus_rdata in the same cycle.
  - Pointer = grant_id+1 (mod MASTER_NUM).
  - Go to IDLE.
  - Minimum request-to-accept latency is 2 cycles.
- GRANT with the watchdog counter equal to TIMEOUT_CYCLES-1 and bus_done=0:
  - Pulse m_error[grant_id].
  - Drive bus_read/bus_write to 0 for one cycle in ABORT, then go to IDLE.
  - Advance the pointer as on completion.

Watchdog:
- The counter clears on entry to GRANT and saturates. Width is clog2(TIMEOUT_CYCLES+1).
- If bus_done and the timeout coincide, done wins: accept, no error.

Boundary rules:
- A requester that drops its request while granted (protocol violation) still holds the grant until done or timeout; the arbiter never silently re-grants.
- Back-to-back: a master re-requesting in the cycle after its accept is evaluated in IDLE like any other. With RR, a competing requester gets the next grant.
- m_stall[i] = request[i] & ~m_accept[i].
- MASTER_NUM=1 degenerates to a pass-through with 1-cycle arbitration. grant_id is 0.
- Reset asserted mid-transaction forces IDLE the next edge with no accept or error pulse. The bus request drops the same edge.

Decomposition:
- The XT_BUS package gains hb_arb_state_e (IDLE, GRANT, ABORT) and the localparam HB_WIDTH_BYTE/HALF/WORD encodings.
- Natural sub-module: rr_priority_picker. Inputs: request vector, pointer, mode. Outputs: one-hot winner and index. It is purely combinational and reusable by a future XT_LB multi-master bridge.

Test Plan:
- Single request, zero-wait slave: m_read[0]=1, raddr=0x0804, bus_rdata=0xDEADBEEF with done immediately in GRANT -> m_accept[0] exactly 2 cycles after request, m_rdata=0xDEADBEEF, bus outputs 0 afterwards.
- RR fairness: MASTER_NUM=3, all three request continuously, done after 1 wait cycle -> grant order 0,1,2,0,1,2; every grant lasts 2 cycles.
- Fixed priority: RR_MODE=0, masters 0 and 2 request continuously -> master 2 never granted while 0 requests; m_stall[2] stays 1.
- Wait states: write wdata=0x12345678, width=1, done held low 5 cycles -> bus_* stable for all 6 GRANT cycles; accept only on cycle 6.
- Timeout: TIMEOUT_CYCLES=8, done never asserted -> m_error pulses on the 8th GRANT cycle, one ABORT cycle with the bus idle, no m_accept. Also check done coincident with the 8th cycle -> accept, no error.
- Reset mid-GRANT: rst_sync_n low during a wait-stated transfer -> next edge all outputs 0, no pulses, pointer 0; after release the first contention is won by master 0.
